mem_port_arbiter: RTL and testbench

//  Shares the single DPI-backed memory port (we/addr/mask/wdata -> rdata) between IFU fetch and LSU load/store.
//  One outstanding transaction at a time; valid/ready request and response channels per requester.

---
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one combinational memory port between IFU fetch and LSU load/store, one transaction
// at a time with LAT-cycle emulated latency. Define ARB_RR_EN for round-robin arbitration.
module mem_port_arbiter #(
  parameter int LAT    = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  input  logic              ifu_resp_ready,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_we,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [7:0]        lsu_wmask,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic              lsu_resp_valid,
  input  logic              lsu_resp_ready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_mask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int   CNT_W   = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  if (LAT < 1) begin : g_lat_check
    $error("mem_port_arbiter: LAT must be >= 1");
  end

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              first_q, first_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        mask_q, mask_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d;
  logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
  logic              grant_ifu, grant_lsu, accept, handshake;
`ifdef ARB_RR_EN
  logic              last_grant_q, last_grant_d;
`endif

  // Grants are only offered in IDLE; the loser simply keeps its valid asserted.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state_q == S_IDLE) begin
`ifdef ARB_RR_EN
      if (ifu_req_valid && lsu_req_valid) begin
        grant_lsu = (last_grant_q == OWN_IFU);
        grant_ifu = (last_grant_q == OWN_LSU);
      end else begin
        grant_lsu = lsu_req_valid;
        grant_ifu = ifu_req_valid;
      end
`else
      grant_lsu = lsu_req_valid;
      grant_ifu = ifu_req_valid && !lsu_req_valid;
`endif
    end
    accept = grant_ifu || grant_lsu;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      owner_q     <= OWN_LSU;
      we_q        <= 1'b0;
      first_q     <= 1'b0;
      addr_q      <= '0;
      mask_q      <= '0;
      wdata_q     <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
`ifdef ARB_RR_EN
      last_grant_q <= OWN_IFU;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      first_q     <= first_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      wdata_q     <= wdata_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
`ifdef ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    mask_d      = mask_q;
    wdata_d     = wdata_q;
    ifu_rdata_d = ifu_rdata_q;
    lsu_rdata_d = lsu_rdata_q;
    first_d     = accept;
    handshake   = (owner_q == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;
`ifdef ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          owner_d = grant_lsu ? OWN_LSU : OWN_IFU;
          we_d    = grant_lsu && lsu_we;
          addr_d  = grant_lsu ? lsu_addr : ifu_addr;
          mask_d  = grant_lsu ? lsu_wmask : 8'h00;
          wdata_d = grant_lsu ? lsu_wdata : '0;
          cnt_d   = CNT_W'(LAT - 1);
          state_d = S_ACCESS;
`ifdef ARB_RR_EN
          last_grant_d = grant_lsu ? OWN_LSU : OWN_IFU;
`endif
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          if (owner_q == OWN_LSU) lsu_rdata_d = mem_rdata;
          else                    ifu_rdata_d = mem_rdata;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (handshake) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The write strobe is gated by the live state so reset removes it without waiting for a clock.
  always_comb begin
    ifu_req_ready  = grant_ifu;
    lsu_req_ready  = grant_lsu;
    ifu_resp_valid = (state_q == S_RESP) && (owner_q == OWN_IFU);
    lsu_resp_valid = (state_q == S_RESP) && (owner_q == OWN_LSU);
    mem_we         = (state_q == S_ACCESS) && first_q && we_q;
  end

  assign mem_addr  = addr_q;
  assign mem_mask  = mask_q;
  assign mem_wdata = wdata_q;
  assign ifu_rdata = ifu_rdata_q;
  assign lsu_rdata = lsu_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: LAT=1 and LAT=4 instances, directed and random
// transactions checked against a transaction-level model of grant, latency and data rules.
module tb_mem_port_arbiter;
  logic        clk;
  logic        rst_n;
  logic        ifu_req_valid, ifu_resp_ready, lsu_req_valid, lsu_resp_ready, lsu_we;
  logic [31:0] ifu_addr, lsu_addr, lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        sel4;
  bit          last_lsu;
  int          checks, errors;

  logic        d1_ifu_req_ready, d1_ifu_resp_valid, d1_lsu_req_ready, d1_lsu_resp_valid, d1_mem_we;
  logic [31:0] d1_ifu_rdata, d1_lsu_rdata, d1_mem_addr, d1_mem_wdata, d1_mem_rdata;
  logic [7:0]  d1_mem_mask;
  logic        d4_ifu_req_ready, d4_ifu_resp_valid, d4_lsu_req_ready, d4_lsu_resp_valid, d4_mem_we;
  logic [31:0] d4_ifu_rdata, d4_lsu_rdata, d4_mem_addr, d4_mem_wdata, d4_mem_rdata;
  logic [7:0]  d4_mem_mask;
  logic        o_ifu_req_ready, o_ifu_resp_valid, o_lsu_req_ready, o_lsu_resp_valid, o_mem_we;
  logic [31:0] o_ifu_rdata, o_lsu_rdata, o_mem_addr, o_mem_wdata;
  logic [7:0]  o_mem_mask;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign d1_mem_rdata = mem_model(d1_mem_addr);
  assign d4_mem_rdata = mem_model(d4_mem_addr);

  mem_port_arbiter #(.LAT(1), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(d1_ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(d1_ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(d1_ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(d1_lsu_req_ready), .lsu_we(lsu_we),
    .lsu_addr(lsu_addr), .lsu_wmask(lsu_wmask), .lsu_wdata(lsu_wdata),
    .lsu_resp_valid(d1_lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(d1_lsu_rdata),
    .mem_we(d1_mem_we), .mem_addr(d1_mem_addr), .mem_mask(d1_mem_mask),
    .mem_wdata(d1_mem_wdata), .mem_rdata(d1_mem_rdata)
  );

  mem_port_arbiter #(.LAT(4), .ADDR_W(32), .DATA_W(32)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(d4_ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(d4_ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(d4_ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(d4_lsu_req_ready), .lsu_we(lsu_we),
    .lsu_addr(lsu_addr), .lsu_wmask(lsu_wmask), .lsu_wdata(lsu_wdata),
    .lsu_resp_valid(d4_lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(d4_lsu_rdata),
    .mem_we(d4_mem_we), .mem_addr(d4_mem_addr), .mem_mask(d4_mem_mask),
    .mem_wdata(d4_mem_wdata), .mem_rdata(d4_mem_rdata)
  );

  // Observe whichever instance the current scenario targets.
  always_comb begin
    o_ifu_req_ready  = sel4 ? d4_ifu_req_ready  : d1_ifu_req_ready;
    o_ifu_resp_valid = sel4 ? d4_ifu_resp_valid : d1_ifu_resp_valid;
    o_lsu_req_ready  = sel4 ? d4_lsu_req_ready  : d1_lsu_req_ready;
    o_lsu_resp_valid = sel4 ? d4_lsu_resp_valid : d1_lsu_resp_valid;
    o_mem_we         = sel4 ? d4_mem_we         : d1_mem_we;
    o_ifu_rdata      = sel4 ? d4_ifu_rdata      : d1_ifu_rdata;
    o_lsu_rdata      = sel4 ? d4_lsu_rdata      : d1_lsu_rdata;
    o_mem_addr       = sel4 ? d4_mem_addr       : d1_mem_addr;
    o_mem_wdata      = sel4 ? d4_mem_wdata      : d1_mem_wdata;
    o_mem_mask       = sel4 ? d4_mem_mask       : d1_mem_mask;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic do_reset();
    ifu_req_valid = 0; lsu_req_valid = 0; ifu_resp_ready = 0; lsu_resp_ready = 0;
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    last_lsu = 0;
  endtask

  // One complete transaction starting at a negedge with the DUT idle; ends at the negedge after the handshake.
  task automatic run_txn(input string tag, input bit v_ifu, input bit v_lsu, input bit we,
                         input logic [31:0] iaddr, input logic [31:0] laddr,
                         input logic [31:0] wdata, input logic [7:0] mask, input int hold);
    bit          exp_lsu, exp_we;
    logic [31:0] exp_addr, exp_rdata, got_rdata;
    int          lat;
    lat = sel4 ? 4 : 1;
    ifu_req_valid = v_ifu; ifu_addr = iaddr;
    lsu_req_valid = v_lsu; lsu_we = we; lsu_addr = laddr; lsu_wdata = wdata; lsu_wmask = mask;
    ifu_resp_ready = 0; lsu_resp_ready = 0;
`ifdef ARB_RR_EN
    exp_lsu = (v_ifu && v_lsu) ? !last_lsu : v_lsu;
`else
    exp_lsu = v_lsu;
`endif
    exp_we    = exp_lsu && we;
    exp_addr  = exp_lsu ? laddr : iaddr;
    exp_rdata = mem_model(exp_addr);
    #1;
    checks++;
    if (o_lsu_req_ready !== exp_lsu || o_ifu_req_ready !== (v_ifu && !exp_lsu)) begin
      errors++;
      $display("[TB] FAIL %s grant: got ifu_ready=%b lsu_ready=%b, expected ifu_ready=%b lsu_ready=%b",
               tag, o_ifu_req_ready, o_lsu_req_ready, v_ifu && !exp_lsu, exp_lsu);
    end
    last_lsu = exp_lsu;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (exp_lsu) lsu_req_valid = 0;
        else         ifu_req_valid = 0;
      end
      checks++;
      if (o_mem_we !== ((k == 0) && exp_we) || o_mem_addr !== exp_addr ||
          (exp_we && (o_mem_mask !== mask || o_mem_wdata !== wdata)) ||
          o_ifu_resp_valid !== 1'b0 || o_lsu_resp_valid !== 1'b0 ||
          o_ifu_req_ready !== 1'b0 || o_lsu_req_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s access%0d: got we=%b addr=%h mask=%h wdata=%h rv=%b%b rr=%b%b, expected we=%b addr=%h mask=%h wdata=%h rv=00 rr=00",
                 tag, k, o_mem_we, o_mem_addr, o_mem_mask, o_mem_wdata, o_ifu_resp_valid,
                 o_lsu_resp_valid, o_ifu_req_ready, o_lsu_req_ready, (k == 0) && exp_we,
                 exp_addr, mask, wdata);
      end
    end
    @(negedge clk);
    got_rdata = exp_lsu ? o_lsu_rdata : o_ifu_rdata;
    checks++;
    if (o_lsu_resp_valid !== exp_lsu || o_ifu_resp_valid !== !exp_lsu ||
        (!exp_we && got_rdata !== exp_rdata) || o_mem_we !== 1'b0 || o_mem_addr !== exp_addr) begin
      errors++;
      $display("[TB] FAIL %s response: got ifu_rv=%b lsu_rv=%b rdata=%h we=%b addr=%h, expected ifu_rv=%b lsu_rv=%b rdata=%h we=0 addr=%h",
               tag, o_ifu_resp_valid, o_lsu_resp_valid, got_rdata, o_mem_we, o_mem_addr,
               !exp_lsu, exp_lsu, exp_rdata, exp_addr);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (o_lsu_resp_valid !== exp_lsu || o_ifu_resp_valid !== !exp_lsu ||
          (exp_lsu ? o_lsu_rdata : o_ifu_rdata) !== got_rdata ||
          o_ifu_req_ready !== 1'b0 || o_lsu_req_ready !== 1'b0 || o_mem_we !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s stall%0d: got rv=%b%b rdata=%h rr=%b%b we=%b, expected rv=%b%b rdata=%h rr=00 we=0",
                 tag, h, o_ifu_resp_valid, o_lsu_resp_valid, exp_lsu ? o_lsu_rdata : o_ifu_rdata,
                 o_ifu_req_ready, o_lsu_req_ready, o_mem_we, !exp_lsu, exp_lsu, got_rdata);
      end
    end
    if (exp_lsu) lsu_resp_ready = 1;
    else         ifu_resp_ready = 1;
    @(negedge clk);
    lsu_resp_ready = 0; ifu_resp_ready = 0;
    checks++;
    if (o_ifu_resp_valid !== 1'b0 || o_lsu_resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s release: got ifu_rv=%b lsu_rv=%b, expected 0 0",
               tag, o_ifu_resp_valid, o_lsu_resp_valid);
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (o_ifu_req_ready !== 1'b0 || o_lsu_req_ready !== 1'b0 || o_ifu_resp_valid !== 1'b0 ||
        o_lsu_resp_valid !== 1'b0 || o_mem_we !== 1'b0 || o_mem_addr !== 32'h0 ||
        o_mem_mask !== 8'h0 || o_mem_wdata !== 32'h0 || o_ifu_rdata !== 32'h0 ||
        o_lsu_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL %s: got rr=%b%b rv=%b%b we=%b addr=%h mask=%h wdata=%h irdata=%h lrdata=%h, expected all zero",
               tag, o_ifu_req_ready, o_lsu_req_ready, o_ifu_resp_valid, o_lsu_resp_valid,
               o_mem_we, o_mem_addr, o_mem_mask, o_mem_wdata, o_ifu_rdata, o_lsu_rdata);
    end
  endtask

  task automatic test_reset();
    sel4 = 0;
    do_reset();
    #1 check_zero("reset_lat1");
    sel4 = 1;
    #1 check_zero("reset_lat4");
    sel4 = 0;
    @(negedge clk);
    run_txn("pre_reset", 1, 0, 0, 32'h1234_5678, 32'h0, 32'h0, 8'h0, 0);
    rst_n = 0;
    #1 check_zero("reset_after_txn");
    @(negedge clk);
    rst_n = 1;
    last_lsu = 0;
  endtask

  task automatic test_ifu_read();
    run_txn("ifu_read", 1, 0, 0, 32'h8000_0000, 32'h0, 32'h0, 8'h0, 0);
  endtask

  task automatic test_lsu_store();
    run_txn("lsu_store", 0, 1, 1, 32'h0, 32'h8000_1000, 32'hDEAD_BEEF, 8'h0F, 0);
    run_txn("lsu_load", 0, 1, 0, 32'h0, 32'h8000_1004, 32'h0, 8'h0, 1);
  endtask

  task automatic test_tie_rounds();
    do_reset();
    for (int r = 0; r < 4; r++)
      run_txn("tie", 1, 1, 0, 32'h8000_0100 + 32'(r), 32'h8000_2000 + 32'(r), 32'h0, 8'h0, 0);
    if (last_lsu) run_txn("tie_drain", 1, 0, 0, 32'h8000_0103, 32'h0, 32'h0, 8'h0, 0);
    else          run_txn("tie_drain", 0, 1, 0, 32'h0, 32'h8000_2003, 32'h0, 8'h0, 0);
  endtask

  task automatic test_resp_stall();
    do_reset();
    run_txn("stall_lsu", 1, 1, 0, 32'h8000_0040, 32'h8000_3000, 32'h0, 8'h0, 5);
    run_txn("after_stall_ifu", 1, 0, 0, 32'h8000_0040, 32'h0, 32'h0, 8'h0, 0);
  endtask

  task automatic test_random(input int n);
    bit          pi, pl, we;
    logic [31:0] ia, la, wd;
    logic [7:0]  mk;
    pi = 0; pl = 0; we = 0; ia = 0; la = 0; wd = 0; mk = 0;
    for (int t = 0; t < n; t++) begin
      if (!pi && $urandom_range(0, 1) == 1) begin
        pi = 1; ia = $urandom;
      end
      if (!pl && ($urandom_range(0, 1) == 1 || !pi)) begin
        pl = 1; la = $urandom; wd = $urandom;
        we = 1'($urandom_range(0, 1)); mk = 8'($urandom_range(0, 255));
      end
      run_txn("random", pi, pl, we, ia, la, wd, mk, $urandom_range(0, 3));
      if (last_lsu) pl = 0;
      else          pi = 0;
    end
    if (pi || pl) run_txn("random_drain", pi, pl, we, ia, la, wd, mk, 0);
  endtask

  task automatic test_lat4();
    sel4 = 1;
    do_reset();
    run_txn("lat4_load", 0, 1, 0, 32'h0, 32'h8000_4000, 32'h0, 8'h0, 0);
    run_txn("lat4_store", 0, 1, 1, 32'h0, 32'h8000_4008, 32'h0BAD_F00D, 8'hA5, 2);
    run_txn("lat4_ifu", 1, 0, 0, 32'h8000_0000, 32'h0, 32'h0, 8'h0, 0);
  endtask

  task automatic test_reset_mid();
    int stale;
    sel4 = 1;
    do_reset();
    lsu_req_valid = 1; lsu_we = 1; lsu_addr = 32'h8000_5000;
    lsu_wdata = 32'hCAFE_F00D; lsu_wmask = 8'hFF;
    @(negedge clk);
    lsu_req_valid = 0;
    checks++;
    if (o_mem_we !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_strobe: got mem_we=%b, expected 1", o_mem_we);
    end
    rst_n = 0;
    #1;
    checks++;
    if (o_mem_we !== 1'b0 || o_lsu_resp_valid !== 1'b0 || o_mem_addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_store: got we=%b rv=%b addr=%h, expected 0 0 0",
               o_mem_we, o_lsu_resp_valid, o_mem_addr);
    end
    @(negedge clk);
    rst_n = 1;
    last_lsu = 0;
    lsu_req_valid = 1; lsu_we = 0; lsu_addr = 32'h8000_5010;
    @(negedge clk);
    lsu_req_valid = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if (o_mem_we !== 1'b0 || o_lsu_resp_valid !== 1'b0 || o_lsu_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_load: got we=%b rv=%b rdata=%h, expected 0 0 0",
               o_mem_we, o_lsu_resp_valid, o_lsu_rdata);
    end
    @(negedge clk);
    rst_n = 1;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (o_lsu_resp_valid !== 1'b0 || o_ifu_resp_valid !== 1'b0 || o_mem_we !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("[TB] FAIL midreset_stale: got %0d cycles with activity, expected 0", stale);
    end
    run_txn("after_midreset", 0, 1, 0, 32'h0, 32'h8000_5020, 32'h0, 8'h0, 0);
  endtask

  initial begin
    checks = 0; errors = 0; sel4 = 0; last_lsu = 0;
    ifu_req_valid = 0; ifu_resp_ready = 0; ifu_addr = 0;
    lsu_req_valid = 0; lsu_resp_ready = 0; lsu_we = 0;
    lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
    rst_n = 0;
    test_reset();
    test_ifu_read();
    test_lsu_store();
    test_tie_rounds();
    test_resp_stall();
    sel4 = 0;
    do_reset();
    test_random(40);
    sel4 = 1;
    do_reset();
    test_random(15);
    test_lat4();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
